// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: counters, syncs, blank and strobes from the timing
// generator to pixel generators and the compositor.
interface vga_timing_gen_if;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync;
   logic        vsync;
   logic        blank;
   logic        pix_tick;
   logic        line_start;
   logic        frame_start;

   modport master (
      output hcount, vcount, hsync, vsync, blank,
             pix_tick, line_start, frame_start
   );

   modport slave (
      input  hcount, vcount, hsync, vsync, blank,
             pix_tick, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source (hcount/vcount, hsync/vsync, blank,
// pix_tick, line_start, frame_start) advanced by an internal pixel-clock-enable
// divider. Default timing is 640x480@60 from a 50 MHz clk with CLK_DIV=2.
//
// Optional feature macro: VGA_SYNC_DELAY_EN
//   When defined, hsync/vsync/blank are each delayed by SYNC_DLY extra clk
//   stages so they line up with a registered pixel path. Counters and strobes
//   stay undelayed. When undefined, SYNC_DLY has no effect.
//
// All outputs are registered and decoded from the next-state counter values,
// so sync/blank always describe the hcount/vcount presented in the same cycle.
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int SYNC_DLY = 2
) (
   input  logic             clk,
   input  logic             rst,   // asynchronous, active-low
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Divider width; a 1-bit counter that never leaves 0 covers CLK_DIV=1.
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

   // Range bounds are held one bit wider so a sync pulse ending exactly at
   // a 2048-pixel / 1024-line total still compares correctly.
   localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
   localparam logic [11:0] HS_BEG    = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
   localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic          tick_q, tick_d;
   logic [10:0]   h_q, h_d;
   logic [9:0]    v_q, v_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          bl_q, bl_d;
   logic          ls_q, ls_d;
   logic          fs_q, fs_d;
   logic          h_wrap;

   // Next-state: divider, counters, strobes and decode of the next position.
   always_comb begin
      div_d  = '0;
      tick_d = 1'b0;
      h_wrap = 1'b0;
      h_d    = h_q;
      v_d    = v_q;
      ls_d   = 1'b0;
      fs_d   = 1'b0;
      hs_d   = ~H_POL;
      vs_d   = ~V_POL;
      bl_d   = 1'b0;

      // Divider wraps at CLK_DIV-1; tick is the registered decode of that
      // terminal count, so it is high in the cycle the counter sits there.
      if (div_q != DIV_MAX) begin
         div_d = div_q + DW'(1);
      end
      tick_d = (div_d == DIV_MAX);

      // Counters only move on an edge where the tick is high.
      if (tick_q) begin
         if (h_q == H_LAST) begin
            h_wrap = 1'b1;
            h_d    = '0;
         end else begin
            h_d    = h_q + 11'd1;
         end
      end

      if (h_wrap) begin
         if (v_q == V_LAST) begin
            v_d = '0;
         end else begin
            v_d = v_q + 10'd1;
         end
      end

      // Strobes mark the cycle in which the wrapped value is first shown.
      ls_d = h_wrap;
      fs_d = h_wrap && (v_q == V_LAST);

      if (({1'b0, h_d} >= HS_BEG) && ({1'b0, h_d} < HS_END)) begin
         hs_d = H_POL;
      end
      if (({1'b0, v_d} >= VS_BEG) && ({1'b0, v_d} < VS_END)) begin
         vs_d = V_POL;
      end
      bl_d = ({1'b0, h_d} >= H_ACT_END) || ({1'b0, v_d} >= V_ACT_END);
   end

   // State and output registers; reset parks at (0,0) with syncs inactive.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q  <= '0;
         tick_q <= 1'b0;
         h_q    <= '0;
         v_q    <= '0;
         hs_q   <= ~H_POL;
         vs_q   <= ~V_POL;
         bl_q   <= 1'b0;
         ls_q   <= 1'b0;
         fs_q   <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
         h_q    <= h_d;
         v_q    <= v_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         bl_q   <= bl_d;
         ls_q   <= ls_d;
         fs_q   <= fs_d;
      end
   end

   assign vga.hcount      = h_q;
   assign vga.vcount      = v_q;
   assign vga.pix_tick    = tick_q;
   assign vga.line_start  = ls_q;
   assign vga.frame_start = fs_q;

`ifdef VGA_SYNC_DELAY_EN
   // Extra alignment stages for syncs and blank; index SYNC_DLY-1 is the tap.
   logic hs_pipe_q [SYNC_DLY];
   logic vs_pipe_q [SYNC_DLY];
   logic bl_pipe_q [SYNC_DLY];

   // Shift every clk, independent of the pixel tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_DLY; i++) begin
            hs_pipe_q[i] <= ~H_POL;
            vs_pipe_q[i] <= ~V_POL;
            bl_pipe_q[i] <= 1'b0;
         end
      end else begin
         hs_pipe_q[0] <= hs_q;
         vs_pipe_q[0] <= vs_q;
         bl_pipe_q[0] <= bl_q;
         for (int i = 1; i < SYNC_DLY; i++) begin
            hs_pipe_q[i] <= hs_pipe_q[i-1];
            vs_pipe_q[i] <= vs_pipe_q[i-1];
            bl_pipe_q[i] <= bl_pipe_q[i-1];
         end
      end
   end

   assign vga.hsync = hs_pipe_q[SYNC_DLY-1];
   assign vga.vsync = vs_pipe_q[SYNC_DLY-1];
   assign vga.blank = bl_pipe_q[SYNC_DLY-1];
`else
   assign vga.hsync = hs_q;
   assign vga.vsync = vs_q;
   assign vga.blank = bl_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-timing instances (divided and undivided
// pixel clock, both sync polarities) compared every clk against a model that
// derives the raster position from elapsed clocks since reset release.
module tb_vga_timing_gen;

   localparam int SDLY = 2;

   typedef struct {
      int d, ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
      bit hpol, vpol;
   } cfg_t;

   typedef struct packed {
      logic [10:0] h;
      logic [9:0]  v;
      logic        hs, vs, bl, pt, ls, fs;
   } exp_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   k;          // clk edges since the latest reset release
   cfg_t ca, cb;

   vga_timing_gen_if ifa ();
   vga_timing_gen_if ifb ();

   vga_timing_gen #(
      .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b0), .SYNC_DLY(SDLY)
   ) dut_a (.clk(clk), .rst(rst), .vga(ifa));

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b0), .SYNC_DLY(SDLY)
   ) dut_b (.clk(clk), .rst(rst), .vga(ifb));

   exp_t obs_a, obs_b;
   assign obs_a = {ifa.hcount, ifa.vcount, ifa.hsync, ifa.vsync, ifa.blank,
                   ifa.pix_tick, ifa.line_start, ifa.frame_start};
   assign obs_b = {ifb.hcount, ifb.vcount, ifb.hsync, ifb.vsync, ifb.blank,
                   ifb.pix_tick, ifb.line_start, ifb.frame_start};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int htot(cfg_t c);
      return c.ha + c.hfp + c.hsw + c.hbp;
   endfunction

   function automatic int vtot(cfg_t c);
      return c.va + c.vfp + c.vsw + c.vbp;
   endfunction

   // Pixels advanced after k edges: the first tick appears after CLK_DIV-1
   // edges (after one edge when undivided) and each tick is consumed one edge later.
   function automatic int pcount(cfg_t c, int kk);
      if (kk <= 0) return 0;
      if (c.d == 1) return kk - 1;
      return kk / c.d;
   endfunction

   function automatic exp_t model(cfg_t c, int kk);
      exp_t e;
      int p, pp, h, v;
      e = '0;
      e.hs = ~c.hpol;
      e.vs = ~c.vpol;
      if (kk <= 0) return e;
      p  = pcount(c, kk);
      pp = pcount(c, kk - 1);
      h  = p % htot(c);
      v  = (p / htot(c)) % vtot(c);
      e.h  = 11'(h);
      e.v  = 10'(v);
      e.hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hpol : ~c.hpol;
      e.vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vpol : ~c.vpol;
      e.bl = (h >= c.ha) || (v >= c.va);
      e.pt = (kk % c.d) == (c.d - 1);
      e.ls = (p != pp) && (h == 0);
      e.fs = e.ls && (v == 0);
      return e;
   endfunction

   // Expected outputs after kk edges, including the optional sync delay.
   function automatic exp_t expect_at(cfg_t c, int kk);
      exp_t e;
      e = model(c, kk);
`ifdef VGA_SYNC_DELAY_EN
      begin
         exp_t dl;
         dl   = model(c, kk - SDLY);
         e.hs = dl.hs;
         e.vs = dl.vs;
         e.bl = dl.bl;
      end
`endif
      return e;
   endfunction

   function automatic string fmt(exp_t e);
      return $sformatf("h=%0d v=%0d hs=%b vs=%b bl=%b pt=%b ls=%b fs=%b",
                       e.h, e.v, e.hs, e.vs, e.bl, e.pt, e.ls, e.fs);
   endfunction

   // Reset held: both instances park at reset values.
   task automatic test_reset();
      exp_t ea, eb;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      ea = expect_at(ca, 0);
      eb = expect_at(cb, 0);
      checks++;
      if (obs_a !== ea) begin
         errors++;
         $display("FAIL reset_a got %s exp %s", fmt(obs_a), fmt(ea));
      end
      checks++;
      if (obs_b !== eb) begin
         errors++;
         $display("FAIL reset_b got %s exp %s", fmt(obs_b), fmt(eb));
      end
   endtask

   // Release reset and scan two full frames plus a random tail, checking
   // every clk, the frame period, counter maxima and frame_start count.
   task automatic test_frames(int extra);
      exp_t ea, eb;
      int   n, last_a, last_b, nfs_a, nfs_b, maxh_a, maxv_a, maxh_b, maxv_b;
      int   per_a, per_b;
      per_a  = htot(ca) * vtot(ca) * ca.d;
      per_b  = htot(cb) * vtot(cb) * cb.d;
      n      = 2 * per_a + extra;
      last_a = -1; last_b = -1; nfs_a = 0; nfs_b = 0;
      maxh_a = 0;  maxv_a = 0;  maxh_b = 0; maxv_b = 0;
      @(negedge clk);
      rst = 1'b1;
      k   = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         k++;
         #1;
         ea = expect_at(ca, k);
         eb = expect_at(cb, k);
         checks++;
         if (obs_a !== ea) begin
            errors++;
            $display("FAIL scan_a k=%0d got %s exp %s", k, fmt(obs_a), fmt(ea));
         end
         checks++;
         if (obs_b !== eb) begin
            errors++;
            $display("FAIL scan_b k=%0d got %s exp %s", k, fmt(obs_b), fmt(eb));
         end
         if (int'(ifa.hcount) > maxh_a) maxh_a = int'(ifa.hcount);
         if (int'(ifa.vcount) > maxv_a) maxv_a = int'(ifa.vcount);
         if (int'(ifb.hcount) > maxh_b) maxh_b = int'(ifb.hcount);
         if (int'(ifb.vcount) > maxv_b) maxv_b = int'(ifb.vcount);
         if (ifa.frame_start === 1'b1) begin
            if (last_a >= 0) begin
               checks++;
               if (k - last_a !== per_a) begin
                  errors++;
                  $display("FAIL frame_period_a got %0d exp %0d", k - last_a, per_a);
               end
            end
            last_a = k;
            nfs_a++;
         end
         if (ifb.frame_start === 1'b1) begin
            if (last_b >= 0) begin
               checks++;
               if (k - last_b !== per_b) begin
                  errors++;
                  $display("FAIL frame_period_b got %0d exp %0d", k - last_b, per_b);
               end
            end
            last_b = k;
            nfs_b++;
         end
      end
      checks++;
      if (maxh_a !== htot(ca) - 1 || maxv_a !== vtot(ca) - 1) begin
         errors++;
         $display("FAIL max_a got %0d/%0d exp %0d/%0d", maxh_a, maxv_a, htot(ca) - 1, vtot(ca) - 1);
      end
      checks++;
      if (maxh_b !== htot(cb) - 1 || maxv_b !== vtot(cb) - 1) begin
         errors++;
         $display("FAIL max_b got %0d/%0d exp %0d/%0d", maxh_b, maxv_b, htot(cb) - 1, vtot(cb) - 1);
      end
      checks++;
      if (nfs_a !== pcount(ca, k) / (htot(ca) * vtot(ca))) begin
         errors++;
         $display("FAIL frames_a got %0d exp %0d", nfs_a, pcount(ca, k) / (htot(ca) * vtot(ca)));
      end
      checks++;
      if (nfs_b !== pcount(cb, k) / (htot(cb) * vtot(cb))) begin
         errors++;
         $display("FAIL frames_b got %0d exp %0d", nfs_b, pcount(cb, k) / (htot(cb) * vtot(cb)));
      end
   endtask

   // Reset asserted at random raster positions between clk edges: outputs
   // must drop immediately, hold for 3 clks, and restart cleanly at (0,0).
   task automatic test_mid_reset(int iters);
      exp_t ea, eb;
      int   run;
      for (int it = 0; it < iters; it++) begin
         run = int'($urandom_range(40, 700));
         for (int i = 0; i < run; i++) begin
            @(posedge clk);
            k++;
            #1;
            ea = expect_at(ca, k);
            eb = expect_at(cb, k);
            checks++;
            if (obs_a !== ea) begin
               errors++;
               $display("FAIL run_a k=%0d got %s exp %s", k, fmt(obs_a), fmt(ea));
            end
            checks++;
            if (obs_b !== eb) begin
               errors++;
               $display("FAIL run_b k=%0d got %s exp %s", k, fmt(obs_b), fmt(eb));
            end
         end
         @(negedge clk);
         #2;
         rst = 1'b0;
         #1;
         ea = expect_at(ca, 0);
         eb = expect_at(cb, 0);
         checks++;
         if (obs_a !== ea) begin
            errors++;
            $display("FAIL async_rst_a got %s exp %s", fmt(obs_a), fmt(ea));
         end
         checks++;
         if (obs_b !== eb) begin
            errors++;
            $display("FAIL async_rst_b got %s exp %s", fmt(obs_b), fmt(eb));
         end
         repeat (3) @(posedge clk);
         #1;
         checks++;
         if (obs_a !== ea || obs_b !== eb) begin
            errors++;
            $display("FAIL rst_hold got %s / %s exp %s / %s", fmt(obs_a), fmt(obs_b), fmt(ea), fmt(eb));
         end
         @(negedge clk);
         rst = 1'b1;
         k   = 0;
      end
      // Tail after the final restart covers the first ticks and no spurious strobe.
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         k++;
         #1;
         ea = expect_at(ca, k);
         eb = expect_at(cb, k);
         checks++;
         if (obs_a !== ea) begin
            errors++;
            $display("FAIL restart_a k=%0d got %s exp %s", k, fmt(obs_a), fmt(ea));
         end
         checks++;
         if (obs_b !== eb) begin
            errors++;
            $display("FAIL restart_b k=%0d got %s exp %s", k, fmt(obs_b), fmt(eb));
         end
      end
   endtask

   initial begin
      ca = '{d:2, ha:16, hfp:2, hsw:3, hbp:2, va:6, vfp:1, vsw:2, vbp:1, hpol:1'b0, vpol:1'b0};
      cb = '{d:1, ha:8, hfp:2, hsw:2, hbp:2, va:4, vfp:1, vsw:1, vbp:1, hpol:1'b1, vpol:1'b0};
      rst = 1'b0;
      k   = 0;
      test_reset();
      test_frames(int'($urandom_range(5, 120)));
      test_mid_reset(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
